flopr_resp_checker: RTL and testbench
=====================================

# flopr_resp_checker

Synthesizable response checker for the parameterized reset register `flopr`. It samples the register output `q` once per clock over a fixed run of check slots and compares each sample against a golden sequence held in the shared package. It accumulates a mismatch count, records the first failing slot, and reports pass/fail. It sits at the receiving end of the register stimulus path, so register checks can run on-board or in any bench without hand inspection of waveforms.

## Interface
Parameters:
- `N`, 64, data width of the observed register.
- `DEPTH`, 10, number of check slots per run.
- `HOLD`, 5, number of leading slots during which the DUT is held in reset; the expected value in these slots is 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `obs`  in  N  observed register output (`q` of the DUT).
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `pass`  out  1  high in DONE when `err_count == 0`; 0 otherwise.
- `mismatch`  out  1  one-cycle pulse, registered, for each failing slot.
- `err_count`  out  8  number of failing slots; saturates at 255.
- `first_err_idx`  out  $clog2(DEPTH)  first failing slot index; all-ones when there is no error.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE after slot DEPTH-1 is compared.
  - DONE -> RUN on `start`.
  - Any state -> IDLE on `reset`.
- Entering RUN: slot index `idx` <- 0, `err_count` <- 0, `first_err_idx` <- all-ones.
- Expected value for slot k:
  - 0 when k < HOLD.
  - `EXP_VEC[k-1]` otherwise, reflecting the one-cycle latency of the register.
- `EXP_VEC[0..9]` = AAAA_AAAA_AAAA_AAA{A,B,C,D,E,F,1,2,3,4}, zero-extended or truncated to N.
- On each RUN edge:
  - Compare the full-width `obs` against the expected value for slot `idx`.
  - On mismatch: increment `err_count` (saturating), set `mismatch`, and latch `idx` into `first_err_idx` if it is still all-ones.
  - Increment `idx` (no wrap needed; the FSM exits at DEPTH-1).
- `start` is ignored while in RUN.
- DONE holds all result outputs stable until `start` or `reset`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, `mismatch`=0, `err_count`=0, `first_err_idx`=all-ones, `idx`=0.
- `start` is sampled at edge E0. Slot 0 samples `obs` at edge E1, and slot k at edge E1+k.
- `busy` is high from after E0 through the edge that compares the last slot.
- `done` and `pass` are valid the cycle after the last compare, i.e. DEPTH+1 cycles after `start`.
- `mismatch` for slot k is high for exactly the cycle after edge E1+k.
- Reset mid-run aborts the run and all outputs return to their reset values next cycle.
- `reset` and `start` high together: reset wins.
- `start` in DONE behaves like `start` in IDLE; the previous results are cleared on the same edge.

## Structure
- Package `flopr_chk_pkg` holds:
  - the `state_t` enum (IDLE/RUN/DONE);
  - the `EXP_VEC` constant array;
  - function `exp_at(k, HOLD)` returning the expected slot value.
- Natural sub-module: `sat_counter` (8-bit counter with saturating increment and synchronous clear), used for `err_count`.
- Everything else stays in one module: FSM, slot counter, comparator, first-error latch.

## Test plan
1. Feed the correct stream (0 for slots 0–4, then AAAE, AAAF, AAA1, AAA2, AAA3) -> `done` 11 cycles after `start`, `pass`=1, `err_count`=0, `first_err_idx`=F, no `mismatch` pulse.
2. Same stream with slot 7 forced to 0 -> `err_count`=1, `first_err_idx`=7, exactly one `mismatch` pulse, `pass`=0.
3. `obs` held at 0 for the whole run -> slots 5–9 fail, `err_count`=5, `first_err_idx`=5, five consecutive `mismatch` pulses.
4. Assert `reset` during slot 4 -> next cycle IDLE with all reset values; a fresh `start` with the correct stream -> `pass`=1.
5. Pulse `start` again during RUN -> ignored, `done` timing unchanged. Then pulse `start` in DONE -> counters cleared and a new run begins.
6. Assert `reset` and `start` on the same edge -> stays IDLE, `busy`=0.

Source files
------------

// File: rtl/flopr_chk_pkg.sv
// Shared types, golden response table and expected-value helper for the flopr response checker.
// Combinational only; no latency, no backpressure.
package flopr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W   = 8;
    localparam int EXP_W   = 64;
    localparam int NUM_EXP = 10;
    localparam int EXP_IW  = 4;

    localparam logic [EXP_W-1:0] EXP_VEC [NUM_EXP] = '{
        64'hAAAA_AAAA_AAAA_AAAA,
        64'hAAAA_AAAA_AAAA_AAAB,
        64'hAAAA_AAAA_AAAA_AAAC,
        64'hAAAA_AAAA_AAAA_AAAD,
        64'hAAAA_AAAA_AAAA_AAAE,
        64'hAAAA_AAAA_AAAA_AAAF,
        64'hAAAA_AAAA_AAAA_AAA1,
        64'hAAAA_AAAA_AAAA_AAA2,
        64'hAAAA_AAAA_AAAA_AAA3,
        64'hAAAA_AAAA_AAAA_AAA4
    };

    // Slot k sees the register one cycle late, hence the k-1 lookup once out of reset.
    function automatic logic [EXP_W-1:0] exp_at(input int k, input int hold);
        if (k < hold || k < 1 || k > NUM_EXP) begin
            return '0;
        end
        return EXP_VEC[EXP_IW'(k - 1)];
    endfunction

endpackage

// File: rtl/flopr_resp_checker_if.sv
// Checker-side bundle: run control, observed data and result reporting.
// Plain wires; timing and flow control are owned by the checker.
interface flopr_resp_checker_if
    import flopr_chk_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 10
);
    localparam int IW = $clog2(DEPTH);

    logic             start;
    logic [N-1:0]     obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [IW-1:0]    first_err_idx;

    modport master (
        output start, obs,
        input  busy, done, pass, mismatch, err_count, first_err_idx
    );

    modport slave (
        input  start, obs,
        output busy, done, pass, mismatch, err_count, first_err_idx
    );

endinterface

// File: rtl/sat_counter.sv
// Error counter: synchronous clear, increment that sticks at all-ones.
// Count updates one cycle after inc/clr; never stalls.
module sat_counter
    import flopr_chk_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/flopr_resp_checker.sv
// Samples obs once per slot for DEPTH slots after start and scores it against the golden sequence.
// Results valid DEPTH+1 cycles after start; start is ignored while a run is in flight.
module flopr_resp_checker
    import flopr_chk_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 10,
    parameter int HOLD  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    flopr_resp_checker_if.slave   chk
);

    localparam int IW = $clog2(DEPTH);
    localparam int WW = (N > EXP_W) ? N : EXP_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    first_err_q, first_err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_q, mismatch_d;

    logic [CNT_W-1:0] err_count;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [WW-1:0]    exp_w;
    logic [N-1:0]     exp_n;
    logic             slot_miss;

    // Golden value is zero-extended or truncated to the observed width.
    assign exp_w     = WW'(exp_at(32'(idx_q), HOLD));
    assign exp_n     = exp_w[N-1:0];
    assign slot_miss = (chk.obs != exp_n);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        first_err_d = first_err_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        mismatch_d  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (chk.start) begin
                    state_d     = RUN;
                    idx_d       = '0;
                    first_err_d = '1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            RUN: begin
                mismatch_d = slot_miss;
                cnt_inc    = slot_miss;
                if (slot_miss && (first_err_q == '1)) begin
                    first_err_d = idx_q;
                end
                idx_d = idx_q + IW'(1);
                // Counter updates on this same edge, so fold in the current slot's verdict.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count == '0) && !slot_miss;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            first_err_q <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_err_q <= first_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            mismatch_q  <= mismatch_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (err_count)
    );

    assign chk.busy          = busy_q;
    assign chk.done          = done_q;
    assign chk.pass          = pass_q;
    assign chk.mismatch      = mismatch_q;
    assign chk.err_count     = err_count;
    assign chk.first_err_idx = first_err_q;

endmodule

// File: tb/tb_flopr_resp_checker.sv
// Directed bench for flopr_resp_checker: correct stream, single/multiple faults, reset abort, start handling.
module tb_flopr_resp_checker;

    localparam int N     = 64;
    localparam int DEPTH = 10;
    localparam int HOLD  = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    flopr_resp_checker_if #(.N(N), .DEPTH(DEPTH)) bus ();

    flopr_resp_checker #(
        .N     (N),
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .chk   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses;
    int start_at;

    logic [N-1:0] gold [DEPTH];
    logic [N-1:0] stim [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
        check({tag, "_pass"},  64'(bus.pass), 64'd0);
        check({tag, "_mis"},   64'(bus.mismatch), 64'd0);
        check({tag, "_err"},   64'(bus.err_count), 64'd0);
        check({tag, "_fidx"},  64'(bus.first_err_idx), 64'hF);
    endtask

    // Feeds stim[0..n-1], one slot per edge; start already sampled at E0.
    task automatic run_slots(input int n);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            bus.obs   = stim[k];
            bus.start = (k == start_at);
            tick();
            bus.start = 1'b0;
            if (bus.mismatch === 1'b1) pulses++;
            check($sformatf("mis_slot%0d", k), 64'(bus.mismatch), 64'(stim[k] !== gold[k]));
            if (k < DEPTH - 1) begin
                check($sformatf("busy_slot%0d", k), 64'(bus.busy), 64'd1);
                check($sformatf("done_slot%0d", k), 64'(bus.done), 64'd0);
            end
        end
        bus.obs = '0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        gold[0] = '0;
        gold[1] = '0;
        gold[2] = '0;
        gold[3] = '0;
        gold[4] = '0;
        gold[5] = 64'hAAAA_AAAA_AAAA_AAAE;
        gold[6] = 64'hAAAA_AAAA_AAAA_AAAF;
        gold[7] = 64'hAAAA_AAAA_AAAA_AAA1;
        gold[8] = 64'hAAAA_AAAA_AAAA_AAA2;
        gold[9] = 64'hAAAA_AAAA_AAAA_AAA3;
        start_at  = -1;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.obs   = '0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("idle");

        // Correct stream: done appears 11 edges after start is raised.
        foreach (stim[i]) stim[i] = gold[i];
        start_run();
        run_slots(DEPTH);
        check("t1_done",   64'(bus.done), 64'd1);
        check("t1_busy",   64'(bus.busy), 64'd0);
        check("t1_pass",   64'(bus.pass), 64'd1);
        check("t1_err",    64'(bus.err_count), 64'd0);
        check("t1_fidx",   64'(bus.first_err_idx), 64'hF);
        check("t1_pulses", 64'(pulses), 64'd0);
        tick();
        tick();
        check("t1_hold_done", 64'(bus.done), 64'd1);
        check("t1_hold_pass", 64'(bus.pass), 64'd1);

        // Slot 7 corrupted; restarted from DONE.
        stim[7] = '0;
        start_run();
        run_slots(DEPTH);
        check("t2_done",   64'(bus.done), 64'd1);
        check("t2_pass",   64'(bus.pass), 64'd0);
        check("t2_err",    64'(bus.err_count), 64'd1);
        check("t2_fidx",   64'(bus.first_err_idx), 64'd7);
        check("t2_pulses", 64'(pulses), 64'd1);

        // obs stuck at zero: slots 5..9 fail.
        foreach (stim[i]) stim[i] = '0;
        start_run();
        run_slots(DEPTH);
        check("t3_pass",   64'(bus.pass), 64'd0);
        check("t3_err",    64'(bus.err_count), 64'd5);
        check("t3_fidx",   64'(bus.first_err_idx), 64'd5);
        check("t3_pulses", 64'(pulses), 64'd5);

        // Reset during slot 4 after a slot-3 failure.
        foreach (stim[i]) stim[i] = gold[i];
        stim[3] = 64'd1;
        start_run();
        run_slots(4);
        check("t4_pre_err", 64'(bus.err_count), 64'd1);
        check("t4_pre_mis", 64'(bus.mismatch), 64'd1);
        bus.obs = stim[4];
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("t4_abort");
        tick();
        check_idle("t4_stay");
        foreach (stim[i]) stim[i] = gold[i];
        start_run();
        run_slots(DEPTH);
        check("t4_done", 64'(bus.done), 64'd1);
        check("t4_pass", 64'(bus.pass), 64'd1);

        // start pulsed mid-run is ignored; slot 6 fails so clearing on restart is visible.
        stim[6]  = 64'd0;
        start_at = 3;
        start_run();
        run_slots(DEPTH);
        start_at = -1;
        check("t5_done", 64'(bus.done), 64'd1);
        check("t5_err",  64'(bus.err_count), 64'd1);
        check("t5_fidx", 64'(bus.first_err_idx), 64'd6);
        start_run();
        check("t5_clr_err",  64'(bus.err_count), 64'd0);
        check("t5_clr_fidx", 64'(bus.first_err_idx), 64'hF);
        check("t5_clr_pass", 64'(bus.pass), 64'd0);
        foreach (stim[i]) stim[i] = gold[i];
        run_slots(DEPTH);
        check("t5_done2", 64'(bus.done), 64'd1);
        check("t5_pass2", 64'(bus.pass), 64'd1);

        // reset and start together: reset wins, no run begins.
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check_idle("t6_both");
        tick();
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_done", 64'(bus.done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
